// File: rtl/msi_dcache_ctrl_p.sv
// MSI data-cache controller: CPU port <-> external tag/data array, snoop bus and unified memory.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss/write-back counters.
module msi_dcache_ctrl_p #(
  parameter int  ADDR_W = 13,
  parameter int  WORD_W = 16,
  parameter int  WPL    = 4,
  localparam int OFS_W  = $clog2(WPL),
  localparam int LINE_W = WORD_W * WPL,
  localparam int LA_W   = ADDR_W - OFS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              we,
  input  logic              re,
  output logic [WORD_W-1:0] rd_data,
  output logic              d_rdy,
  output logic [LA_W-1:0]   c_idx,
  output logic              c_re,
  output logic              c_we,
  output logic [LINE_W-1:0] c_wr_line,
  output logic [1:0]        c_wstate,
  input  logic [LINE_W-1:0] c_rd_line,
  input  logic              c_hit,
  input  logic [1:0]        c_rstate,
  input  logic [LA_W-1:0]   c_victim_tag,
  output logic              bus_req,
  input  logic              grant,
  output logic [1:0]        bus_cmd,
  output logic [LA_W-1:0]   bus_addr,
  input  logic              inv_in,
  input  logic [LA_W-1:0]   inv_addr,
  input  logic              peer_valid,
  input  logic [LINE_W-1:0] peer_line,
  output logic [LA_W-1:0]   u_addr,
  output logic              u_we,
  output logic              u_re,
  output logic [LINE_W-1:0] u_wr_line,
  input  logic              u_rdy,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt,
`endif
  input  logic [LINE_W-1:0] u_rd_line
);

  localparam logic [1:0] ST_INV = 2'd0, ST_SHR = 2'd1, ST_MOD = 2'd2;
  localparam logic [1:0] CMD_NONE = 2'd0, CMD_RD = 2'd1, CMD_RDX = 2'd2, CMD_UPGR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_UPGR, S_EVICT, S_FILL_REQ, S_FILL_WAIT, S_FILL_WR, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                store_q, store_d;
  logic                gnt_q, gnt_d;
  logic [LA_W-1:0]     req_line;
  logic [OFS_W-1:0]    req_ofs;

  assign req_line = addr_q[ADDR_W-1:OFS_W];
  assign req_ofs  = addr_q[OFS_W-1:0];

  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [OFS_W-1:0] ofs);
    return line[int'(ofs)*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFS_W-1:0] ofs,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] r;
    r = line;
    r[int'(ofs)*WORD_W +: WORD_W] = word;
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    line_d    = line_q;
    store_d   = store_q;
    gnt_d     = gnt_q;
    rd_data   = word_sel(line_q, req_ofs);
    d_rdy     = 1'b0;
    c_idx     = req_line;
    c_re      = 1'b0;
    c_we      = 1'b0;
    c_wr_line = merge_word(line_q, req_ofs, wdata_q);
    c_wstate  = ST_INV;
    bus_req   = 1'b0;
    bus_cmd   = CMD_NONE;
    bus_addr  = req_line;
    u_addr    = req_line;
    u_we      = 1'b0;
    u_re      = 1'b0;
    u_wr_line = line_q;
    case (state_q)
      S_IDLE: begin
        c_re    = 1'b1;
        c_idx   = addr[ADDR_W-1:OFS_W];
        rd_data = word_sel(c_rd_line, addr[OFS_W-1:0]);
        d_rdy   = 1'b1;
        if (we && c_hit && c_rstate == ST_MOD) begin
          c_we      = 1'b1;
          c_wr_line = merge_word(c_rd_line, addr[OFS_W-1:0], wr_data);
          c_wstate  = ST_MOD;
        end else if (we || (re && !c_hit)) begin
          // Store to a shared line, or any miss: capture the request and the indexed line.
          d_rdy   = 1'b0;
          addr_d  = addr;
          wdata_d = wr_data;
          store_d = we;
          line_d  = c_rd_line;
          gnt_d   = 1'b0;
          if (c_hit)                 state_d = S_UPGR;
          else if (c_rstate == ST_MOD) state_d = S_EVICT;
          else                       state_d = S_FILL_REQ;
        end
      end
      S_UPGR: begin
        bus_req = 1'b1;
        bus_cmd = CMD_UPGR;
        // A remote invalidate of our line before grant means the copy is gone: refetch exclusively.
        if (inv_in && inv_addr == req_line) begin
          state_d = S_FILL_REQ;
        end else if (grant) begin
          c_we     = 1'b1;
          c_wstate = ST_MOD;
          state_d  = S_DONE;
        end
      end
      S_EVICT: begin
        bus_req = !gnt_q;
        u_we    = gnt_q || grant;
        u_addr  = c_victim_tag;
        if (!gnt_q && grant) gnt_d = 1'b1;
        if (u_we && u_rdy) begin
          gnt_d   = 1'b0;
          state_d = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        bus_req = 1'b1;
        bus_cmd = store_q ? CMD_RDX : CMD_RD;
        if (grant) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        u_re = 1'b1;
        if (peer_valid) begin
          line_d  = peer_line;
          state_d = S_FILL_WR;
        end else if (u_rdy) begin
          line_d  = u_rd_line;
          state_d = S_FILL_WR;
        end
      end
      S_FILL_WR: begin
        c_we = 1'b1;
        if (store_q) begin
          c_wstate = ST_MOD;
        end else begin
          c_wr_line = line_q;
          c_wstate  = ST_SHR;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        d_rdy   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // While reset is held no array, bus or memory action may leak out.
    if (rst_n) begin
      d_rdy     = 1'b1;
      c_re      = 1'b0;
      c_we      = 1'b0;
      bus_req   = 1'b0;
      bus_cmd   = CMD_NONE;
      u_we      = 1'b0;
      u_re      = 1'b0;
      u_addr    = '0;
      u_wr_line = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      store_q <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
      store_q <= store_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == S_IDLE && (we || re)) begin
      if (c_hit) hit_cnt_d  = sat_inc(hit_cnt_q);
      else       miss_cnt_d = sat_inc(miss_cnt_q);
    end
    if (state_q == S_EVICT && u_we && u_rdy) wb_cnt_d = sat_inc(wb_cnt_q);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_msi_dcache_ctrl_p.sv
// Directed bench for msi_dcache_ctrl_p: bench plays array, bus arbiter, peer and memory,
// and a transaction-level model predicts array writes, write-backs, bus commands and latency.
`timescale 1ns/1ps
module tb_msi_dcache_ctrl_p;
  localparam int ADDR_W = 13, WORD_W = 16, WPL = 4, LA_W = 11, LINE_W = 64;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;
  localparam logic [63:0] L0     = 64'h4444_3333_2222_1111;
  localparam logic [63:0] MEM_L  = 64'hA3A3_A2A2_A1A1_A0A0;
  localparam logic [63:0] PEER_L = 64'hC3C3_C2C2_C1C1_C0C0;
  localparam logic [63:0] VIC_L  = 64'hD3D3_D2D2_D1D1_D0D0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic we = 1'b0, re = 1'b0;
  logic [WORD_W-1:0] rd_data;
  logic d_rdy;
  logic [LA_W-1:0] c_idx;
  logic c_re, c_we;
  logic [LINE_W-1:0] c_wr_line;
  logic [1:0] c_wstate;
  logic [LINE_W-1:0] c_rd_line = '0;
  logic c_hit = 1'b0;
  logic [1:0] c_rstate = ST_I;
  logic [LA_W-1:0] c_victim_tag = '0;
  logic bus_req;
  logic grant = 1'b0;
  logic [1:0] bus_cmd;
  logic [LA_W-1:0] bus_addr;
  logic inv_in = 1'b0;
  logic [LA_W-1:0] inv_addr = '0;
  logic peer_valid = 1'b0;
  logic [LINE_W-1:0] peer_line = PEER_L;
  logic [LA_W-1:0] u_addr;
  logic u_we, u_re;
  logic [LINE_W-1:0] u_wr_line;
  logic u_rdy = 1'b0;
  logic [LINE_W-1:0] u_rd_line = MEM_L;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  msi_dcache_ctrl_p #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .WPL(WPL)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .we(we), .re(re),
    .rd_data(rd_data), .d_rdy(d_rdy), .c_idx(c_idx), .c_re(c_re), .c_we(c_we),
    .c_wr_line(c_wr_line), .c_wstate(c_wstate), .c_rd_line(c_rd_line), .c_hit(c_hit),
    .c_rstate(c_rstate), .c_victim_tag(c_victim_tag), .bus_req(bus_req), .grant(grant),
    .bus_cmd(bus_cmd), .bus_addr(bus_addr), .inv_in(inv_in), .inv_addr(inv_addr),
    .peer_valid(peer_valid), .peer_line(peer_line), .u_addr(u_addr), .u_we(u_we),
    .u_re(u_re), .u_wr_line(u_wr_line), .u_rdy(u_rdy),
`ifdef DCACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt),
`endif
    .u_rd_line(u_rd_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LA_W-1:0]   a;
    logic [LINE_W-1:0] line;
    logic [1:0]        st;
  } ev_t;

  ev_t cw_q[$];
  ev_t mw_q[$];
  ev_t bus_q[$];

  int checks = 0;
  int errors = 0;
  logic [LINE_W-1:0] last_cw_line = '0;
  logic [LA_W-1:0]   last_u_addr = '0;
  logic [WORD_W-1:0] last_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [63:0] line, input int ofs);
    return 16'(line >> (16 * ofs));
  endfunction

  function automatic logic [63:0] put_word(input logic [63:0] line, input int ofs,
                                           input logic [15:0] w);
    return (line & ~(64'hFFFF << (16 * ofs))) | (64'(w) << (16 * ofs));
  endfunction

  // Every observable array write, memory write-back and granted bus command is matched
  // against the next prediction in its queue.
  always @(negedge clk) begin : cmp
    ev_t e;
    if (c_we) begin
      chk("cw_pending", 64'(cw_q.size() != 0), 64'd1);
      if (cw_q.size() != 0) begin
        e = cw_q.pop_front();
        chk("c_idx", 64'(c_idx), 64'(e.a));
        chk("c_wr_line", c_wr_line, e.line);
        chk("c_wstate", 64'(c_wstate), 64'(e.st));
      end
      last_cw_line = c_wr_line;
    end
    if (u_we && u_rdy) begin
      chk("mw_pending", 64'(mw_q.size() != 0), 64'd1);
      if (mw_q.size() != 0) begin
        e = mw_q.pop_front();
        chk("u_addr", 64'(u_addr), 64'(e.a));
        chk("u_wr_line", u_wr_line, e.line);
      end
      last_u_addr = u_addr;
    end
    if (bus_req && grant) begin
      chk("bus_pending", 64'(bus_q.size() != 0), 64'd1);
      if (bus_q.size() != 0) begin
        e = bus_q.pop_front();
        chk("bus_cmd", 64'(bus_cmd), 64'(e.st));
        chk("bus_addr", 64'(bus_addr), 64'(e.a));
      end
    end
  end

  task automatic push(ref ev_t q[$], input logic [LA_W-1:0] a, input logic [63:0] line,
                      input logic [1:0] st);
    ev_t e;
    e.a = a; e.line = line; e.st = st;
    q.push_back(e);
  endtask

  // pm: 0 memory fills, 1 peer only, 2 peer and memory in the same cycle.
  task automatic run_access(input string nm, input bit st_op, input logic [12:0] a,
                            input logic [15:0] wd, input bit hit, input logic [1:0] rst_st,
                            input logic [63:0] line, input logic [10:0] vtag, input int gw,
                            input int mw, input int pm, input int inv_cyc,
                            input logic [10:0] inv_a);
    logic [10:0] la;
    logic [63:0] fill;
    logic [15:0] exp_rd;
    int ofs, exp_lat, cyc, bcnt, mcnt, lat;
    bit race, done, chk_rd;
    la = a[12:2];
    ofs = int'(a[1:0]);
    fill = (pm != 0) ? PEER_L : MEM_L;
    race = hit && st_op && rst_st == ST_S && inv_cyc >= 1 && inv_a == la && inv_cyc < 1 + gw;
    chk_rd = !st_op;
    exp_rd = '0;
    if (hit && !st_op) begin
      exp_lat = 0;
      exp_rd = word_of(line, ofs);
    end else if (hit && rst_st == ST_M) begin
      exp_lat = 0;
      push(cw_q, la, put_word(line, ofs, wd), ST_M);
    end else if (hit && !race) begin
      exp_lat = 2 + gw;
      push(bus_q, la, '0, 2'd3);
      push(cw_q, la, put_word(line, ofs, wd), ST_M);
    end else begin
      exp_lat = 4 + gw + mw;
      if (!hit && rst_st == ST_M) begin
        exp_lat += 1 + gw + mw;
        push(mw_q, vtag, line, ST_I);
        push(bus_q, la, '0, 2'd0);
      end
      push(bus_q, la, '0, st_op ? 2'd2 : 2'd1);
      push(cw_q, la, st_op ? put_word(fill, ofs, wd) : fill, st_op ? ST_M : ST_S);
      exp_rd = word_of(fill, ofs);
    end

    @(posedge clk); #1;
    c_hit = hit; c_rstate = rst_st; c_rd_line = line; c_victim_tag = vtag;
    addr = a; wr_data = wd; we = st_op; re = !st_op;
    cyc = 0; bcnt = 0; mcnt = 0; done = 1'b0; lat = -1;
    while (!done && cyc < 80) begin
      inv_in = (cyc == inv_cyc);
      inv_addr = inv_a;
      grant = 1'b0;
      if (bus_req) begin
        if (bcnt == gw) begin grant = 1'b1; bcnt = 0; end
        else bcnt++;
      end
      #1;
      u_rdy = 1'b0; peer_valid = 1'b0;
      if (u_we || u_re) begin
        if (mcnt == mw) begin
          mcnt = 0;
          if (u_re && pm != 0) begin peer_valid = 1'b1; u_rdy = (pm == 2); end
          else u_rdy = 1'b1;
        end else mcnt++;
      end
      @(negedge clk);
      if (d_rdy) begin
        done = 1'b1;
        lat = cyc;
        last_rd = rd_data;
        if (chk_rd) chk({nm, "_rd"}, 64'(rd_data), 64'(exp_rd));
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; grant = 1'b0; u_rdy = 1'b0; peer_valid = 1'b0; inv_in = 1'b0;
    @(negedge clk);
    chk({nm, "_cw_left"}, 64'(cw_q.size()), 64'd0);
    chk({nm, "_mw_left"}, 64'(mw_q.size()), 64'd0);
    chk({nm, "_bus_left"}, 64'(bus_q.size()), 64'd0);
    cw_q.delete(); mw_q.delete(); bus_q.delete();
  endtask

  initial begin
    #1;
    chk("rst_d_rdy", 64'(d_rdy), 64'd1);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_cmd", 64'(bus_cmd), 64'd0);
    chk("rst_strobes", 64'({c_re, c_we, u_we, u_re}), 64'd0);
    chk("rst_u_addr", 64'(u_addr), 64'd0);
    chk("rst_u_wr_line", u_wr_line, 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("idle_c_re", 64'(c_re), 64'd1);

    run_access("load_hit", 1'b0, 13'h0005, 16'h0, 1'b1, ST_S, L0, 11'h0, 0, 0, 0, -1, 11'h0);
    chk("lit_load_hit_rd", 64'(last_rd), 64'h2222);
    run_access("store_hit_m", 1'b1, 13'h0003, 16'h1234, 1'b1, ST_M, L0, 11'h0, 0, 0, 0, -1, 11'h0);
    run_access("upgrade", 1'b1, 13'h0006, 16'hBEEF, 1'b1, ST_S, L0, 11'h0, 3, 0, 0, 1, 11'h2AA);
    chk("lit_upgrade_line", last_cw_line, 64'h4444_BEEF_2222_1111);
    run_access("upg_race", 1'b1, 13'h0006, 16'hBEEF, 1'b1, ST_S, L0, 11'h0, 3, 0, 0, 2, 11'h001);
    chk("lit_race_line", last_cw_line, 64'hA3A3_BEEF_A1A1_A0A0);
    run_access("dirty_load", 1'b0, 13'h0101, 16'h0, 1'b0, ST_M, VIC_L, 11'h012, 1, 2, 0, -1, 11'h0);
    chk("lit_wb_addr", 64'(last_u_addr), 64'h012);
    chk("lit_dirty_rd", 64'(last_rd), 64'hA1A1);
    run_access("peer_both", 1'b0, 13'h0202, 16'h0, 1'b0, ST_S, L0, 11'h0, 0, 1, 2, -1, 11'h0);
    chk("lit_peer_line", last_cw_line, 64'hC3C3_C2C2_C1C1_C0C0);
    run_access("store_miss", 1'b1, 13'h07FF, 16'h5A5A, 1'b0, ST_I, L0, 11'h0, 2, 0, 1, -1, 11'h0);
    run_access("dirty_store", 1'b1, 13'h0010, 16'h0F0F, 1'b0, ST_M, VIC_L, 11'h7AB, 0, 0, 0, -1, 11'h0);
    run_access("hit_top", 1'b0, 13'h1FFC, 16'h0, 1'b1, ST_M, L0, 11'h0, 0, 0, 0, -1, 11'h0);

    // A stray grant with no request outstanding must do nothing.
    @(posedge clk); #1 grant = 1'b1;
    @(negedge clk);
    chk("stray_grant_bus_req", 64'(bus_req), 64'd0);
    @(posedge clk); #1 grant = 1'b0;
    @(negedge clk);
    chk("stray_grant_d_rdy", 64'(d_rdy), 64'd1);
`ifdef DCACHE_STATS_EN
    chk("stat_hit", 64'(hit_cnt), 64'd5);
    chk("stat_miss", 64'(miss_cnt), 64'd4);
    chk("stat_wb", 64'(wb_cnt), 64'd2);
`endif

    // Abort a clean load miss while it waits in FILL_WAIT.
    push(bus_q, 11'h101, '0, 2'd1);
    @(posedge clk); #1;
    c_hit = 1'b0; c_rstate = ST_S; c_rd_line = L0; addr = 13'h0404; re = 1'b1;
    @(posedge clk); #1 grant = bus_req;
    @(posedge clk); #1 grant = 1'b0;
    @(negedge clk);
    chk("abort_u_re", 64'(u_re), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1; re = 1'b0;
    #1;
    chk("abort_d_rdy", 64'(d_rdy), 64'd1);
    chk("abort_strobes", 64'({c_re, c_we, u_we, u_re, bus_req}), 64'd0);
    chk("abort_u_addr", 64'(u_addr), 64'd0);
`ifdef DCACHE_STATS_EN
    chk("abort_cnts", 64'(hit_cnt | miss_cnt | wb_cnt), 64'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b0; u_rdy = 1'b1;
    @(negedge clk);
    chk("post_abort_d_rdy", 64'(d_rdy), 64'd1);
    chk("post_abort_idle", 64'({c_re, c_we, u_re, bus_req}), 64'b1000);
    chk("abort_bus_left", 64'(bus_q.size()), 64'd0);
    @(posedge clk); #1 u_rdy = 1'b0;
    @(negedge clk);
    chk("post_abort_no_write", 64'(c_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/msi_dcache_ctrl_p.md
Name: msi_dcache_ctrl_p

Overview:
- Parametrised successor to the single-core MSI data-cache controller.
- Sits between the CPU data port, an external MSI tag/data array (msi_cache-style), the shared snoop bus and unified memory.
- Generalises word width, line size and address width.
- Adds behaviour the previous generation lacked: modified-victim write-back, bus upgrade (S->M), a bus request/grant handshake, and resolution of the upgrade-vs-remote-invalidate race.

Parameters:
ADDR_W, 13, CPU word address width
WORD_W, 16, data word width
WPL, 4, words per line (power of 2, >=2); OFS_W=$clog2(WPL), LINE_W=WORD_W*WPL, LA_W=ADDR_W-OFS_W

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-high (asserted when 1)
addr  in  ADDR_W  CPU word address
wr_data  in  WORD_W  CPU store data
we  in  1  CPU store request
re  in  1  CPU load request
rd_data  out  WORD_W  load data
d_rdy  out  1  access complete / controller free
c_idx  out  LA_W  line address to array
c_re  out  1  array read
c_we  out  1  array write
c_wr_line  out  LINE_W  line to write
c_wstate  out  2  MSI state to write (INVALID/SHARED/MODIFIED)
c_rd_line  in  LINE_W  array read line
c_hit  in  1  tag match with state != INVALID
c_rstate  in  2  state of indexed line
c_victim_tag  in  LA_W  line address of resident (victim) line
bus_req  out  1  bus request
grant  in  1  bus grant
bus_cmd  out  2  0 none, 1 BusRd, 2 BusRdX, 3 BusUpgr
bus_addr  out  LA_W  line address on bus
inv_in  in  1  remote invalidate valid
inv_addr  in  LA_W  remote invalidate line address
peer_valid  in  1  peer cache supplies fill line
peer_line  in  LINE_W  peer fill data
u_addr  out  LA_W  memory line address
u_we  out  1  memory write
u_re  out  1  memory read
u_wr_line  out  LINE_W  write-back data
u_rdy  in  1  memory op done
u_rd_line  in  LINE_W  memory fill data

Behaviour:
- Reset: state=IDLE; d_rdy=1; all strobes, bus_req and u_* = 0; bus_cmd=0; latched addr/data/line registers = 0.
- IDLE:
  - we has priority over re.
  - c_re=1 and c_idx=addr[ADDR_W-1:OFS_W] combinationally.
  - rd_data = word addr[OFS_W-1:0] of c_rd_line.
- Load hit: d_rdy=1 same cycle; no state change.
- Store hit, M: c_we=1, word merged into c_rd_line, c_wstate=M, d_rdy=1; 0-cycle.
- Store hit, S: latch addr/wr_data; d_rdy=0; go to UPGR.
- Miss (any access): latch request.
  - Victim is MODIFIED: go to EVICT.
  - Otherwise: go to FILL_REQ.
- UPGR:
  - bus_req=1, bus_cmd=3.
  - grant: write merged line, c_wstate=M; go to DONE.
  - inv_in with inv_addr equal to the latched line before grant: drop to FILL_REQ with BusRdX (line lost; store re-fetched).
- EVICT:
  - bus_req=1; u_we=1 after grant.
  - u_addr=c_victim_tag; u_wr_line = victim line captured on entry.
  - Hold until u_rdy; then FILL_REQ.
- FILL_REQ: bus_req=1, bus_cmd=1 (load) or 2 (store); on grant go to FILL_WAIT.
- FILL_WAIT:
  - u_re=1.
  - peer_valid takes priority over u_rdy; same-cycle both uses peer_line.
  - Captured line goes to FILL_WR.
- FILL_WR:
  - c_we=1.
  - Store: line merged with latched wr_data, c_wstate=M.
  - Load: c_wstate=S, rd_data from filled line.
  - Then DONE.
- DONE:
  - d_rdy=1 for exactly one cycle; return to IDLE.
  - New re/we are not sampled in DONE.
- bus_req is held from its raise until grant; grant without bus_req is ignored.
- inv_in outside UPGR is ignored here (the array handles it).
- we/re changing mid-miss is ignored; the latched request wins.
- Reset mid-operation aborts to IDLE with no array or memory write.
- Latency from request to d_rdy=1:
  - Hit: 0 cycles.
  - Upgrade: 2 + grant wait.
  - Clean miss: 4 + grant + memory wait.
  - Dirty miss: add 1 + grant + memory wait.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs hit_cnt, miss_cnt, wb_cnt, 32-bit each, reset 0, saturating at all-ones.
  - hit_cnt increments on an IDLE hit.
  - miss_cnt increments on miss entry.
  - wb_cnt increments on EVICT completion.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load hit, line S, addr=0x0005 -> rd_data = word 1 of line, d_rdy stays 1, no bus_req.
- Store 0xBEEF to S line, grant after 3 cycles -> bus_cmd=3, c_wstate=M, word merged, d_rdy pulses in DONE.
- Store to S line, inv_in matching before grant -> BusRdX issued, u_re, filled line written M with 0xBEEF merged.
- Load miss, victim M tag 0x12 -> u_we, u_addr=0x12, victim data written back, then BusRd fill, c_wstate=S.
- Load miss, peer_valid and u_rdy same cycle -> peer_line installed, not u_rd_line.
- Reset asserted in FILL_WAIT -> IDLE, d_rdy=1, no c_we; with DCACHE_STATS_EN, counters read 0.
